// File: rtl/raxm_pkg.sv
// Shared constants for the approximate-multiplier Wishbone page: register
// offsets, CTRL/STATUS bit positions, field widths and reset values.
package raxm_pkg;

    localparam int K_W = 4;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_OPA     = 8'h04;
    localparam logic [7:0] OFF_OPB     = 8'h08;
    localparam logic [7:0] OFF_STATUS  = 8'h0C;
    localparam logic [7:0] OFF_RESULT  = 8'h10;
    localparam logic [7:0] OFF_ACC     = 8'h14;
    localparam logic [7:0] OFF_OVF_CLR = 8'h18;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ACC_EN  = 1;
    localparam int CTRL_ACC_CLR = 2;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_K_LSB   = 4;

    localparam int ST_BUSY    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    typedef struct packed {
        logic [K_W-1:0] k;
        logic           irq_en;
        logic           acc_en;
    } ctrl_t;

    localparam ctrl_t       RST_CTRL = '{k: '0, irq_en: 1'b0, acc_en: 1'b0};
    localparam logic [31:0] RST_WORD = 32'h0000_0000;

endpackage

// File: rtl/raxm_result_fifo.sv
// Result FIFO: power-of-two depth, same-cycle push and pop allowed, a pop on
// an empty FIFO is ignored and the head reads through combinationally.
module raxm_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_raxm_pipe.sv
// Wishbone-mapped approximate multiplier: operand truncation, latency-matched
// multiply pipeline with FIFO credit check, result FIFO and wrapping accumulator.
module wb_raxm_pipe
    import raxm_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          PIPE_STAGES = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [31:0] la_data_out,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [WIDTH-1:0] trunc_op(input logic [WIDTH-1:0] v,
                                                  input logic [K_W-1:0]   k);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[i] & (i >= int'(k));
        return r;
    endfunction

    function automatic logic [31:0] approx_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [K_W-1:0]   k);
        logic [2*WIDTH-1:0] p;
        logic [31:0]        r;
        p = {{WIDTH{1'b0}}, trunc_op(a, k)} * {{WIDTH{1'b0}}, trunc_op(b, k)};
        r = '0;
        r[2*WIDTH-1:0] = p;
        return r;
    endfunction

    ctrl_t             ctrl;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              ovf;
    logic [31:0]       acc;

    logic [7:0]        off;
    logic              hit;
    logic              req;
    logic              wr;
    logic              rd;
    logic [31:0]       lane_mask;
    logic [31:0]       rdata;

    logic              wr_ctrl;
    logic              start_req;
    logic              acc_clr;
    logic              credit_ok;
    logic              issue;
    logic [4:0]        in_flight;

    logic [PIPE_STAGES-1:0] vld_p;
    logic [31:0]            prod_p [PIPE_STAGES];

    logic              push;
    logic [31:0]       push_data;
    logic              pop;
    logic [31:0]       fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic              unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

    assign off       = {wbs_adr_i[7:2], 2'b00};
    assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req       = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign wr_ctrl   = wr & (off == OFF_CTRL) & wbs_sel_i[0];
    assign start_req = wr_ctrl & wbs_dat_i[CTRL_START];
    assign acc_clr   = wr_ctrl & wbs_dat_i[CTRL_ACC_CLR];

    // Products still in the pipe hold a FIFO slot, so count them as occupied.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < PIPE_STAGES; i++) in_flight = in_flight + 5'(vld_p[i]);
    end

    assign credit_ok = (6'(fifo_count) + 6'(in_flight)) < 6'(FIFO_DEPTH);
    assign issue     = start_req & credit_ok;

    assign push      = vld_p[PIPE_STAGES-1];
    assign push_data = prod_p[PIPE_STAGES-1];
    assign pop       = rd & (off == OFF_RESULT);
    assign irq_o     = ctrl.irq_en & ~fifo_empty;

    always_comb begin
        rdata = RST_WORD;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_K_LSB +: K_W] = ctrl.k;
                rdata[CTRL_IRQ_EN]       = ctrl.irq_en;
                rdata[CTRL_ACC_EN]       = ctrl.acc_en;
            end
            OFF_OPA:    rdata[WIDTH-1:0] = opa;
            OFF_OPB:    rdata[WIDTH-1:0] = opb;
            OFF_STATUS: begin
                rdata[ST_BUSY]                   = |vld_p;
                rdata[ST_EMPTY]                  = fifo_empty;
                rdata[ST_FULL]                   = fifo_full;
                rdata[ST_OVF]                    = ovf;
                rdata[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
            end
            OFF_RESULT: rdata = fifo_empty ? RST_WORD : fifo_head;
            OFF_ACC:    rdata = acc;
            default:    rdata = RST_WORD;
        endcase
    end

    // Bus side: single-cycle registered ack, register writes on the ack edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= RST_WORD;
            ctrl      <= RST_CTRL;
            opa       <= '0;
            opb       <= '0;
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : RST_WORD;
            if (wr_ctrl) begin
                ctrl.acc_en <= wbs_dat_i[CTRL_ACC_EN];
                ctrl.irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                ctrl.k      <= wbs_dat_i[CTRL_K_LSB +: K_W];
            end
            if (wr && off == OFF_OPA)
                opa <= (opa & ~lane_mask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & lane_mask[WIDTH-1:0]);
            if (wr && off == OFF_OPB)
                opb <= (opb & ~lane_mask[WIDTH-1:0]) | (wbs_dat_i[WIDTH-1:0] & lane_mask[WIDTH-1:0]);
            if (start_req && !credit_ok)
                ovf <= 1'b1;
            else if (wr && off == OFF_OVF_CLR && wbs_sel_i[0] && wbs_dat_i[0])
                ovf <= 1'b0;
        end
    end

    // Stage p0 samples the pre-write operands and k; later stages only delay.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < PIPE_STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        prod_p[0] <= approx_mul(opa, opb, ctrl.k);
        for (int i = 1; i < PIPE_STAGES; i++) prod_p[i] <= prod_p[i-1];
    end

    // Push stage: accumulate (clear wins over a coincident push) and mirror.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc         <= RST_WORD;
            la_data_out <= RST_WORD;
        end else begin
            if (acc_clr)
                acc <= RST_WORD;
            else if (push && ctrl.acc_en)
                acc <= acc + push_data;
            if (push)
                la_data_out <= push_data;
            else if (pop && !fifo_empty)
                la_data_out <= fifo_head;
        end
    end

    raxm_result_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
